// File: rtl/decode_stage_fifo.sv
// -----------------------------------------------------------------------------
// decode_stage_fifo
//
// RV32I decode stage sitting between fetch and execute. Each accepted
// instruction is decoded combinationally into a full record (PC, register
// addresses, sign-extended immediate, funct3, one-hot ALU op, one-hot opcode
// class, exception bits) and buffered in a FIFO_DEPTH-entry elastic FIFO.
// Both sides use valid/ready; ds_i_flush discards everything buffered plus
// the instruction offered in the same cycle.
//
// Optional feature macro: DECODE_RV32M_EN
//   defined   : R-type funct7=0000001 decodes as M-extension, ds_o_alu gains
//               a MULDIV bit (highest index), funct3 selects MUL..REMU.
//   undefined : that encoding is illegal, ds_o_alu is 14 bits.
//
// Ports
//   ds_clk, ds_rst      clock, asynchronous active-low reset
//   ds_i_valid/ds_o_ready/ds_i_instr/ds_i_pc   fetch side (ready = !full)
//   ds_i_flush          synchronous flush, highest priority
//   ds_o_valid/ds_i_ready                      execute side (valid = !empty)
//   ds_o_pc, ds_o_addr_rs1/rs2/rd, ds_o_imm, ds_o_funct3,
//   ds_o_alu, ds_o_opcode, ds_o_exception      head record
//   ds_o_count          FIFO occupancy
// -----------------------------------------------------------------------------
package decode_stage_pkg;

  // One-hot ALU bit indices
  localparam int ALU_ADD    = 0;
  localparam int ALU_SUB    = 1;
  localparam int ALU_SLT    = 2;
  localparam int ALU_SLTU   = 3;
  localparam int ALU_XOR    = 4;
  localparam int ALU_OR     = 5;
  localparam int ALU_AND    = 6;
  localparam int ALU_SLL    = 7;
  localparam int ALU_SRL    = 8;
  localparam int ALU_SRA    = 9;
  localparam int ALU_EQ     = 10;
  localparam int ALU_NEQ    = 11;
  localparam int ALU_GE     = 12;
  localparam int ALU_GEU    = 13;
`ifdef DECODE_RV32M_EN
  localparam int ALU_MULDIV = 14;
  localparam int ALU_W      = 15;
`else
  localparam int ALU_W      = 14;
`endif

  // One-hot opcode class bit indices
  localparam int OPC_RTYPE  = 0;
  localparam int OPC_ITYPE  = 1;
  localparam int OPC_LOAD   = 2;
  localparam int OPC_STORE  = 3;
  localparam int OPC_BRANCH = 4;
  localparam int OPC_JAL    = 5;
  localparam int OPC_JALR   = 6;
  localparam int OPC_LUI    = 7;
  localparam int OPC_AUIPC  = 8;
  localparam int OPC_SYSTEM = 9;
  localparam int OPC_FENCE  = 10;
  localparam int OPC_W      = 11;

  // Major opcode field encodings, instr[6:0]
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

endpackage

module decode_stage_fifo
  import decode_stage_pkg::*;
#(
  parameter int DWIDTH     = 32,
  parameter int IWIDTH     = 32,
  parameter int AWIDTH     = 5,
  parameter int PC_WIDTH   = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                          ds_clk,
  input  logic                          ds_rst,
  input  logic                          ds_i_valid,
  output logic                          ds_o_ready,
  input  logic [IWIDTH-1:0]             ds_i_instr,
  input  logic [PC_WIDTH-1:0]           ds_i_pc,
  input  logic                          ds_i_flush,
  output logic                          ds_o_valid,
  input  logic                          ds_i_ready,
  output logic [PC_WIDTH-1:0]           ds_o_pc,
  output logic [AWIDTH-1:0]             ds_o_addr_rs1,
  output logic [AWIDTH-1:0]             ds_o_addr_rs2,
  output logic [AWIDTH-1:0]             ds_o_addr_rd,
  output logic [DWIDTH-1:0]             ds_o_imm,
  output logic [2:0]                    ds_o_funct3,
  output logic [ALU_W-1:0]              ds_o_alu,
  output logic [OPC_W-1:0]              ds_o_opcode,
  output logic [3:0]                    ds_o_exception,
  output logic [$clog2(FIFO_DEPTH):0]   ds_o_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic [AWIDTH-1:0]   rs1;
    logic [AWIDTH-1:0]   rs2;
    logic [AWIDTH-1:0]   rd;
    logic [DWIDTH-1:0]   imm;
    logic [2:0]          funct3;
    logic [ALU_W-1:0]    alu;
    logic [OPC_W-1:0]    opcode;
    logic [3:0]          exception;
  } rec_t;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic [31:0] instr;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign instr  = ds_i_instr[31:0];
  assign funct7 = instr[31:25];
  assign funct3 = instr[14:12];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'b0};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // ALU op for the funct7=0000000 arithmetic encodings shared by R and I type.
  function automatic logic [ALU_W-1:0] f3_alu(input logic [2:0] f3);
    logic [ALU_W-1:0] v;
    v = '0;
    case (f3)
      3'b000: v[ALU_ADD]  = 1'b1;
      3'b001: v[ALU_SLL]  = 1'b1;
      3'b010: v[ALU_SLT]  = 1'b1;
      3'b011: v[ALU_SLTU] = 1'b1;
      3'b100: v[ALU_XOR]  = 1'b1;
      3'b101: v[ALU_SRL]  = 1'b1;
      3'b110: v[ALU_OR]   = 1'b1;
      3'b111: v[ALU_AND]  = 1'b1;
    endcase
    return v;
  endfunction

  rec_t dec;
  logic illegal;

  // NOTE: every field gets a default before the case so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    dec        = '0;
    illegal    = 1'b0;
    dec.pc     = ds_i_pc;
    dec.funct3 = funct3;
    case (instr[6:0])
      OP_RTYPE: begin
        dec.opcode[OPC_RTYPE] = 1'b1;
        dec.rd  = AWIDTH'(instr[11:7]);
        dec.rs1 = AWIDTH'(instr[19:15]);
        dec.rs2 = AWIDTH'(instr[24:20]);
        if (funct7 == 7'b0000000)                         dec.alu = f3_alu(funct3);
        else if (funct7 == 7'b0100000 && funct3 == 3'b000) dec.alu[ALU_SUB] = 1'b1;
        else if (funct7 == 7'b0100000 && funct3 == 3'b101) dec.alu[ALU_SRA] = 1'b1;
`ifdef DECODE_RV32M_EN
        else if (funct7 == 7'b0000001)                     dec.alu[ALU_MULDIV] = 1'b1;
`endif
        else                                                illegal = 1'b1;
      end
      OP_ITYPE: begin
        dec.opcode[OPC_ITYPE] = 1'b1;
        dec.rd  = AWIDTH'(instr[11:7]);
        dec.rs1 = AWIDTH'(instr[19:15]);
        dec.imm = DWIDTH'($signed(imm_i));
        // Only the shift-immediates constrain funct7; ADDI has no SUB form.
        if (funct3 == 3'b001 && funct7 != 7'b0000000)      illegal = 1'b1;
        else if (funct3 == 3'b101 && funct7 == 7'b0100000) dec.alu[ALU_SRA] = 1'b1;
        else if (funct3 == 3'b101 && funct7 != 7'b0000000) illegal = 1'b1;
        else                                                dec.alu = f3_alu(funct3);
      end
      OP_LOAD: begin
        dec.opcode[OPC_LOAD] = 1'b1;
        dec.rd  = AWIDTH'(instr[11:7]);
        dec.rs1 = AWIDTH'(instr[19:15]);
        dec.imm = DWIDTH'($signed(imm_i));
        case (funct3)
          3'b000, 3'b001, 3'b010, 3'b100, 3'b101: dec.alu[ALU_ADD] = 1'b1;
          default:                                illegal = 1'b1;
        endcase
      end
      OP_STORE: begin
        dec.opcode[OPC_STORE] = 1'b1;
        dec.rs1 = AWIDTH'(instr[19:15]);
        dec.rs2 = AWIDTH'(instr[24:20]);
        dec.imm = DWIDTH'($signed(imm_s));
        case (funct3)
          3'b000, 3'b001, 3'b010: dec.alu[ALU_ADD] = 1'b1;
          default:                illegal = 1'b1;
        endcase
      end
      OP_BRANCH: begin
        dec.opcode[OPC_BRANCH] = 1'b1;
        dec.rs1 = AWIDTH'(instr[19:15]);
        dec.rs2 = AWIDTH'(instr[24:20]);
        dec.imm = DWIDTH'($signed(imm_b));
        case (funct3)
          3'b000:  dec.alu[ALU_EQ]   = 1'b1;
          3'b001:  dec.alu[ALU_NEQ]  = 1'b1;
          3'b100:  dec.alu[ALU_SLT]  = 1'b1;
          3'b101:  dec.alu[ALU_GE]   = 1'b1;
          3'b110:  dec.alu[ALU_SLTU] = 1'b1;
          3'b111:  dec.alu[ALU_GEU]  = 1'b1;
          default: illegal = 1'b1;
        endcase
      end
      OP_JAL: begin
        dec.opcode[OPC_JAL] = 1'b1;
        dec.rd  = AWIDTH'(instr[11:7]);
        dec.imm = DWIDTH'($signed(imm_j));
        dec.alu[ALU_ADD] = 1'b1;
      end
      OP_JALR: begin
        dec.opcode[OPC_JALR] = 1'b1;
        dec.rd  = AWIDTH'(instr[11:7]);
        dec.rs1 = AWIDTH'(instr[19:15]);
        dec.imm = DWIDTH'($signed(imm_i));
        dec.alu[ALU_ADD] = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        dec.opcode[(instr[5]) ? OPC_LUI : OPC_AUIPC] = 1'b1;
        dec.rd  = AWIDTH'(instr[11:7]);
        dec.imm = DWIDTH'($signed(imm_u));
        dec.alu[ALU_ADD] = 1'b1;
      end
      OP_SYSTEM, OP_FENCE: begin
        // I-format layout; these classes drive no ALU operation.
        dec.opcode[(instr[4]) ? OPC_SYSTEM : OPC_FENCE] = 1'b1;
        dec.rd  = AWIDTH'(instr[11:7]);
        dec.rs1 = AWIDTH'(instr[19:15]);
        dec.imm = DWIDTH'($signed(imm_i));
      end
      default: illegal = 1'b1;  // also catches instr[1:0] != 2'b11
    endcase

    dec.exception = {ds_i_pc[1:0] != 2'b00,
                     instr == INSTR_EBREAK,
                     instr == INSTR_ECALL,
                     illegal};
    // Excepting records still travel down the pipe but must not execute.
    if (|dec.exception) dec.alu = '0;
  end

  // ---------------------------------------------------------------------------
  // Elastic FIFO
  // ---------------------------------------------------------------------------
  rec_t            mem [FIFO_DEPTH];
  rec_t            last_q;
  rec_t            head;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            full, empty, push, pop;

  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);
  // Push is gated by full before any same-cycle pop: no pass-through.
  assign push  = ds_i_valid && !full && !ds_i_flush;
  assign pop   = !empty && ds_i_ready && !ds_i_flush;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of evaluation order.
  always_ff @(posedge ds_clk or negedge ds_rst) begin
    if (!ds_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last_q <= '0;
    end else begin
      // Remember what is on the outputs so an empty FIFO keeps showing it.
      if (!empty) last_q <= mem[rd_ptr];
      if (ds_i_flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);  // depth is a power of two: wraps
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // NOTE: storage is deliberately not reset; an entry is only ever read
  // after it has been written, and the reset-visible record comes from last_q.
  always_ff @(posedge ds_clk) begin
    if (push) mem[wr_ptr] <= dec;
  end

  assign head = empty ? last_q : mem[rd_ptr];

  assign ds_o_ready     = !full;
  assign ds_o_valid     = !empty;
  assign ds_o_count     = count;
  assign ds_o_pc        = head.pc;
  assign ds_o_addr_rs1  = head.rs1;
  assign ds_o_addr_rs2  = head.rs2;
  assign ds_o_addr_rd   = head.rd;
  assign ds_o_imm       = head.imm;
  assign ds_o_funct3    = head.funct3;
  assign ds_o_alu       = head.alu;
  assign ds_o_opcode    = head.opcode;
  assign ds_o_exception = head.exception;

endmodule
